// File: rtl/i_cache_dm.sv
// i_cache_dm: direct-mapped instruction cache in front of the fetch queue.
// Line width and depth are parameters. Hits return the line one cycle after
// the request; misses refill the whole line in one beat over a ready/valid
// memory port. Supports fetch abort (branch redirect) and full flush.
//
// Ports
//   i_clk, rst_n             clock (rising edge), async active-low reset
//   pc_in, rd_en, rd_ready   fetch request; accepted when rd_en && rd_ready && !abort
//   abort                    cancel outstanding fetch
//   flush                    invalidate every line at the next edge
//   Dout, Dout_valid         fetched line (word 0 in [31:0]), one-cycle valid pulse
//   mem_req_*                line-aligned refill request
//   mem_rsp_*                refill line, single beat
//
// state      | meaning
// IDLE       | lookups accepted, hits answered next cycle
// MISS_REQ   | refill request presented, waiting for mem_req_ready
// MISS_WAIT  | request issued, waiting for the line
// MISS_DRAIN | fetch aborted after issue, absorb the line without output
module i_cache_dm #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 64
) (
    input  logic                    i_clk,
    input  logic                    rst_n,
    input  logic [ADDR_W-1:0]       pc_in,
    input  logic                    rd_en,
    input  logic                    abort,
    input  logic                    flush,
    output logic                    rd_ready,
    output logic [32*LINE_WORDS-1:0] Dout,
    output logic                    Dout_valid,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_W-1:0]       mem_req_addr,
    input  logic                    mem_rsp_valid,
    input  logic [32*LINE_WORDS-1:0] mem_rsp_data
);

    localparam int LINE_W = 32 * LINE_WORDS;
    localparam int OFF_W  = $clog2(4 * LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        MISS_REQ   = 2'd1,
        MISS_WAIT  = 2'd2,
        MISS_DRAIN = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [LINE_W-1:0]    data_mem [NUM_LINES];

    logic [IDX_W-1:0] lookup_idx;
    logic [TAG_W-1:0] lookup_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             hit;
    logic             accept;
    logic             fill;
    logic             deliver;

    // Byte offset within the line never affects the lookup.
    logic unused_offset;
    assign unused_offset = ^pc_in[OFF_W-1:0];

    assign lookup_idx = pc_in[OFF_W +: IDX_W];
    assign lookup_tag = pc_in[ADDR_W-1 -: TAG_W];
    assign fill_idx   = mem_req_addr[OFF_W +: IDX_W];
    assign fill_tag   = mem_req_addr[ADDR_W-1 -: TAG_W];
    assign hit        = valid_q[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);

    always_comb begin
        state_d       = state_q;
        rd_ready      = (state_q == IDLE) && !flush;
        mem_req_valid = (state_q == MISS_REQ);
        accept        = rd_en && rd_ready && !abort;
        fill          = 1'b0;
        deliver       = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && !hit) state_d = MISS_REQ;
            end
            MISS_REQ: begin
                // A handshake in the abort cycle is already issued: drain it.
                if (mem_req_ready)  state_d = abort ? MISS_DRAIN : MISS_WAIT;
                else if (abort)     state_d = IDLE;
            end
            MISS_WAIT: begin
                if (mem_rsp_valid) begin
                    fill    = 1'b1;
                    deliver = !abort;
                    state_d = IDLE;
                end else if (abort) begin
                    state_d = MISS_DRAIN;
                end
            end
            MISS_DRAIN: begin
                if (mem_rsp_valid) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            mem_req_addr <= '0;
            Dout         <= '0;
            Dout_valid   <= 1'b0;
        end else begin
            state_q    <= state_d;
            Dout_valid <= 1'b0;
            if (accept && hit) begin
                Dout       <= data_mem[lookup_idx];
                Dout_valid <= 1'b1;
            end else if (deliver) begin
                Dout       <= mem_rsp_data;
                Dout_valid <= 1'b1;
            end
            if (accept && !hit) begin
                mem_req_addr <= {pc_in[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            end
            // Flush beats a coincident fill: the line is written but stays invalid.
            if (flush)     valid_q           <= '0;
            else if (fill) valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (fill) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_rsp_data;
        end
    end

endmodule

// File: tb/tb_i_cache_dm.sv
// Bench for i_cache_dm: default instance (4 words x 64 lines) and a
// 8 words x 16 lines instance, sharing stimulus and selected by sel.
module tb_i_cache_dm;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [31:0]  pc;
    logic         rd_en, abort, flush, mreq_rdy, mrsp_v;
    logic [255:0] mrsp_data;
    logic         sel;

    logic         rdy_a, dv_a, mqv_a;
    logic [127:0] dout_a;
    logic [31:0]  mqa_a;
    logic         rdy_b, dv_b, mqv_b;
    logic [255:0] dout_b;
    logic [31:0]  mqa_b;

    logic         rdy, dv, mqv;
    logic [255:0] dout;
    logic [31:0]  mqa;

    assign rdy  = sel ? rdy_b  : rdy_a;
    assign dv   = sel ? dv_b   : dv_a;
    assign mqv  = sel ? mqv_b  : mqv_a;
    assign mqa  = sel ? mqa_b  : mqa_a;
    assign dout = sel ? dout_b : {128'h0, dout_a};

    i_cache_dm u_dut_a (
        .i_clk(clk), .rst_n(rst_n), .pc_in(pc),
        .rd_en(rd_en & ~sel), .abort(abort), .flush(flush & ~sel),
        .rd_ready(rdy_a), .Dout(dout_a), .Dout_valid(dv_a),
        .mem_req_valid(mqv_a), .mem_req_ready(mreq_rdy), .mem_req_addr(mqa_a),
        .mem_rsp_valid(mrsp_v & ~sel), .mem_rsp_data(mrsp_data[127:0])
    );

    i_cache_dm #(.LINE_WORDS(8), .NUM_LINES(16)) u_dut_b (
        .i_clk(clk), .rst_n(rst_n), .pc_in(pc),
        .rd_en(rd_en & sel), .abort(abort), .flush(flush & sel),
        .rd_ready(rdy_b), .Dout(dout_b), .Dout_valid(dv_b),
        .mem_req_valid(mqv_b), .mem_req_ready(mreq_rdy), .mem_req_addr(mqa_b),
        .mem_rsp_valid(mrsp_v & sel), .mem_rsp_data(mrsp_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory image: word w of the line at aligned address al is al ^ (w * 0x11111111).
    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] r;
        logic [31:0]  al;
        r  = '0;
        al = sel ? (a & ~32'h1f) : (a & ~32'hf);
        for (int w = 0; w < 8; w++)
            if (sel || w < 4) r[32*w +: 32] = al ^ (32'h11111111 * w);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one fetch with an always-ready memory; lat counts edges from accept to Dout_valid.
    task automatic fetch(input logic [31:0] a, output int lat, output bit missed, output logic [31:0] raddr);
        pc = a; rd_en = 1'b1; mreq_rdy = 1'b1;
        lat = 0; missed = 1'b0; raddr = '0;
        step();
        rd_en = 1'b0;
        lat = 1;
        while (!dv && lat < 20) begin
            if (mqv && !missed) begin
                missed = 1'b1;
                raddr  = mqa;
                step(); lat++;
                mrsp_v = 1'b1; mrsp_data = line_of(raddr);
                step(); lat++;
                mrsp_v = 1'b0;
            end else begin
                step(); lat++;
            end
        end
    endtask

    // Miss on a, abort while waiting for the line, then let the line arrive.
    task automatic abort_wait(input logic [31:0] a);
        pc = a; rd_en = 1'b1; mreq_rdy = 1'b1;
        step();
        rd_en = 1'b0;
        chk("abw.req_valid", mqv, 1);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abw.dv_after_abort", dv, 0);
        chk("abw.not_ready_drain", rdy, 0);
        mrsp_v = 1'b1; mrsp_data = line_of(a);
        step();
        mrsp_v = 1'b0;
        chk("abw.dv_after_rsp", dv, 0);
        chk("abw.ready_again", rdy, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    int          lat;
    bit          m;
    logic [31:0] ra;
    bit          mv [16];
    int          mt [16];

    initial begin
        rst_n = 1'b0; pc = '0; rd_en = 1'b0; abort = 1'b0; flush = 1'b0;
        mreq_rdy = 1'b0; mrsp_v = 1'b0; mrsp_data = '0; sel = 1'b0;
        #1;
        chk("rst.dv", dv, 0);
        chk("rst.req_valid", mqv, 0);
        chk("rst.req_addr", mqa, 0);
        chk("rst.dout", dout, 0);
        step(); step();
        rst_n = 1'b1;
        #1;
        chk("rst.ready", rdy, 1);

        // cold miss then hit in the same line
        fetch(32'h0, lat, m, ra);
        chk("m0.missed", m, 1);
        chk("m0.addr", ra, 32'h0);
        chk("m0.lat", lat, 3);
        chk("m0.data", dout, 256'h33333333_22222222_11111111_00000000);
        fetch(32'h8, lat, m, ra);
        chk("h8.missed", m, 0);
        chk("h8.lat", lat, 1);
        chk("h8.data", dout, 256'h33333333_22222222_11111111_00000000);
        step();
        chk("hold.dv", dv, 0);
        chk("hold.dout", dout, 256'h33333333_22222222_11111111_00000000);

        // conflict on index 0
        fetch(32'h400, lat, m, ra);
        chk("c400.missed", m, 1);
        chk("c400.addr", ra, 32'h400);
        chk("c400.data", dout, line_of(32'h400));
        fetch(32'h0, lat, m, ra);
        chk("c0.missed", m, 1);
        chk("c0.data", dout, line_of(32'h0));

        // back-to-back hits
        fetch(32'h10, lat, m, ra);
        chk("m10.missed", m, 1);
        pc = 32'h0; rd_en = 1'b1;
        step();
        chk("b2b.dv0", dv, 1);
        chk("b2b.d0", dout, line_of(32'h0));
        pc = 32'h14;
        step();
        rd_en = 1'b0;
        chk("b2b.dv1", dv, 1);
        chk("b2b.d1", dout, line_of(32'h10));
        step();
        chk("b2b.dv_off", dv, 0);

        // abort in MISS_WAIT: line still fills
        abort_wait(32'h20);
        fetch(32'h20, lat, m, ra);
        chk("abw20.lat", lat, 1);
        chk("abw20.data", dout, line_of(32'h20));

        // abort in the response cycle
        pc = 32'h30; rd_en = 1'b1; mreq_rdy = 1'b1;
        step();
        rd_en = 1'b0;
        step();
        abort = 1'b1; mrsp_v = 1'b1; mrsp_data = line_of(32'h30);
        step();
        abort = 1'b0; mrsp_v = 1'b0;
        chk("abr.dv", dv, 0);
        chk("abr.ready", rdy, 1);
        fetch(32'h30, lat, m, ra);
        chk("abr.hit_lat", lat, 1);

        // abort in MISS_REQ before handshake: no fill
        pc = 32'h40; rd_en = 1'b1; mreq_rdy = 1'b0;
        step();
        rd_en = 1'b0;
        chk("abq.req_valid", mqv, 1);
        chk("abq.req_addr", mqa, 32'h40);
        step();
        chk("abq.req_held", mqv, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abq.req_dropped", mqv, 0);
        chk("abq.ready", rdy, 1);
        chk("abq.dv", dv, 0);
        fetch(32'h40, lat, m, ra);
        chk("abq.refetch_miss", m, 1);

        // abort in the handshake cycle: drain the issued request
        pc = 32'h50; rd_en = 1'b1; mreq_rdy = 1'b0;
        step();
        rd_en = 1'b0; mreq_rdy = 1'b1; abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abh.req_dropped", mqv, 0);
        chk("abh.drain_not_ready", rdy, 0);
        mrsp_v = 1'b1; mrsp_data = line_of(32'h50);
        step();
        mrsp_v = 1'b0;
        chk("abh.dv", dv, 0);
        chk("abh.ready", rdy, 1);
        fetch(32'h50, lat, m, ra);
        chk("abh.hit_lat", lat, 1);
        chk("abh.data", dout, line_of(32'h50));

        // flush after fill
        pc = 32'h0; rd_en = 1'b1; flush = 1'b1;
        #1;
        chk("fl.ready_low", rdy, 0);
        step();
        flush = 1'b0; rd_en = 1'b0;
        chk("fl.no_accept", dv, 0);
        fetch(32'h0, lat, m, ra);
        chk("fl.miss0", m, 1);
        fetch(32'h10, lat, m, ra);
        chk("fl.miss10", m, 1);

        // flush coinciding with the fill
        pc = 32'h60; rd_en = 1'b1; mreq_rdy = 1'b1;
        step();
        rd_en = 1'b0;
        step();
        mrsp_v = 1'b1; flush = 1'b1; mrsp_data = line_of(32'h60);
        step();
        mrsp_v = 1'b0; flush = 1'b0;
        chk("flr.dv", dv, 1);
        chk("flr.data", dout, line_of(32'h60));
        fetch(32'h60, lat, m, ra);
        chk("flr.refetch_miss", m, 1);

        // abort in IDLE drops a would-be hit
        pc = 32'h60; rd_en = 1'b1; abort = 1'b1;
        step();
        rd_en = 1'b0; abort = 1'b0;
        chk("abi.dv", dv, 0);
        chk("abi.ready", rdy, 1);

        // 8-word, 16-line instance
        sel = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("b.rst.dv", dv, 0);
        chk("b.rst.dout", dout, 0);
        step();
        rst_n = 1'b1;
        fetch(32'h0, lat, m, ra);
        chk("b.m0.missed", m, 1);
        chk("b.m0.lat", lat, 3);
        chk("b.m0.data", dout,
            256'h77777777_66666666_55555555_44444444_33333333_22222222_11111111_00000000);
        fetch(32'h1c, lat, m, ra);
        chk("b.h1c.lat", lat, 1);
        chk("b.h1c.data", dout, line_of(32'h0));
        fetch(32'h200, lat, m, ra);
        chk("b.c200.missed", m, 1);
        chk("b.c200.addr", ra, 32'h200);
        fetch(32'h0, lat, m, ra);
        chk("b.c0.missed", m, 1);

        for (int i = 0; i < 16; i++) begin
            mv[i] = 1'b0;
            mt[i] = 0;
        end
        mv[0] = 1'b1;
        for (int n = 0; n < 24; n++) begin
            int idx, tg;
            bit pred, ab;
            logic [31:0] a;
            idx  = $urandom_range(0, 3);
            tg   = $urandom_range(0, 3);
            a    = 32'h200 * tg + 32'h20 * idx;
            pred = mv[idx] && (mt[idx] == tg);
            ab   = ($urandom_range(0, 3) == 0);
            if (!ab) begin
                fetch(a, lat, m, ra);
                chk("rnd.miss", m, !pred);
                chk("rnd.data", dout, line_of(a));
                mv[idx] = 1'b1;
                mt[idx] = tg;
            end else if (pred) begin
                pc = a; rd_en = 1'b1; abort = 1'b1;
                step();
                rd_en = 1'b0; abort = 1'b0;
                chk("rnd.abort_hit_dv", dv, 0);
            end else begin
                abort_wait(a);
                mv[idx] = 1'b1;
                mt[idx] = tg;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
